// File: rtl/comparator_seq_nbit_pkg.sv
// Shared constants for the sequential comparator: FSM state encodings and slice width.
package comparator_pkg;

  localparam int unsigned SLICE_W = 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/comparator_seq_nbit_if.sv
// Start/busy/done handshake plus operand and result bus of the sequential comparator.
interface comparator_seq_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             e;
  logic             g;
  logic             l;

  modport master (
    output start, a, b,
    input  busy, done, e, g, l
  );

  modport slave (
    input  start, a, b,
    output busy, done, e, g, l
  );
endinterface

// File: rtl/comparator_seq_nbit_slice.sv
// Combinational 2-bit unsigned magnitude comparator slice.
module comparator_2bit_slice
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic               e,
  output logic               g,
  output logic               l
);

  assign e = (x == y);
  assign g = (x > y);
  assign l = (x < y);

endmodule

// File: rtl/comparator_seq_nbit.sv
// Sequential N-bit unsigned comparator: scans 2-bit slices MSB first, exits on first difference.
module comparator_seq_nbit
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  comparator_seq_nbit_if.slave  bus
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned IdxW   = (SLICES > 1) ? $clog2(SLICES) : 1;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic             l_q, l_d;

  logic [SLICES-1:0][SLICE_W-1:0] a_sl;
  logic [SLICES-1:0][SLICE_W-1:0] b_sl;
  logic                           s_e, s_g, s_l;

  assign a_sl = a_q;
  assign b_sl = b_q;

  comparator_2bit_slice u_slice (
    .x (a_sl[idx_q]),
    .y (b_sl[idx_q]),
    .e (s_e),
    .g (s_g),
    .l (s_l)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    g_d     = g_q;
    l_d     = l_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IdxW'(SLICES - 1);
          e_d     = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (s_g || s_l) begin
          g_d     = s_g;
          l_d     = s_l;
          e_d     = 1'b0;
          state_d = StDone;
        end else if (idx_q == '0) begin
          e_d     = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      g_q     <= g_d;
      l_q     <= l_d;
    end
  end

  // Operands need no reset; they are only read after a capture.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.e    = e_q;
  assign bus.g    = g_q;
  assign bus.l    = l_q;

endmodule

// File: tb/tb_comparator_seq_nbit.sv
// Bench for comparator_seq_nbit: vector table, random pairs, WIDTH=2 sweep, handshake corners.
module tb_comparator_seq_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comparator_seq_nbit_if #(.WIDTH(8)) bus8 ();
  comparator_seq_nbit_if #(.WIDTH(2)) bus2 ();

  comparator_seq_nbit #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  comparator_seq_nbit #(.WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;
  bit sel_v = 1'b0;

  logic m_busy, m_done, m_e, m_g, m_l;
  assign m_busy = sel_v ? bus2.busy : bus8.busy;
  assign m_done = sel_v ? bus2.done : bus8.done;
  assign m_e    = sel_v ? bus2.e    : bus8.e;
  assign m_g    = sel_v ? bus2.g    : bus8.g;
  assign m_l    = sel_v ? bus2.l    : bus8.l;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         exp_egl;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic s);
    if (sel) begin
      bus2.start = s;
      bus2.a     = a[1:0];
      bus2.b     = b[1:0];
    end else begin
      bus8.start = s;
      bus8.a     = a;
      bus8.b     = b;
    end
  endtask

  // Latency = k+1, k = 1-based MSB-first index of the first differing 2-bit slice.
  function automatic int model_lat(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    int msb;
    diff = a ^ b;
    if (diff == 8'd0) return w / 2 + 1;
    msb = 0;
    for (int i = 0; i < 8; i++) if (diff[i]) msb = i;
    return (w / 2 - msb / 2) + 1;
  endfunction

  function automatic int model_egl(input logic [7:0] a, input logic [7:0] b);
    if (a == b) return 4;
    if (a > b) return 2;
    return 1;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
  task automatic run(input bit sel, input int w, input logic [7:0] a, input logic [7:0] b,
                     input int exp_egl, input int exp_lat);
    int lat;
    sel_v = sel;
    drive(sel, a, b, 1'b1);
    @(negedge clk);
    drive(sel, a, b, 1'b0);
    lat = 1;
    while (!m_done && lat < 20) begin
      chk("busy_scan", m_busy, 1);
      chk("egl_scan_zero", {m_e, m_g, m_l}, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_at_done", m_busy, 1);
    chk("egl_at_done", {m_e, m_g, m_l}, exp_egl);
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
    chk("busy_fall", m_busy, 0);
    chk("egl_hold", {m_e, m_g, m_l}, exp_egl);
  endtask

  vec_t vecs[7];
  int   ndone;

  initial begin
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    vecs[0] = '{8'hA5, 8'hA5, 4, 5};
    vecs[1] = '{8'h80, 8'h7F, 2, 2};
    vecs[2] = '{8'h12, 8'h13, 1, 5};
    vecs[3] = '{8'h00, 8'h40, 1, 2};
    vecs[4] = '{8'hFF, 8'h00, 2, 2};
    vecs[5] = '{8'h03, 8'h02, 2, 5};
    vecs[6] = '{8'h10, 8'h20, 1, 3};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_v = bit'(s);
      #0;
      chk("reset_busy", m_busy, 0);
      chk("reset_done", m_done, 0);
      chk("reset_egl", {m_e, m_g, m_l}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each run starts in the first IDLE cycle after the previous done.
    foreach (vecs[i]) run(1'b0, 8, vecs[i].a, vecs[i].b, vecs[i].exp_egl, vecs[i].exp_lat);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? (ra ^ 8'(1 << $urandom_range(7, 0))) : 8'($urandom);
      run(1'b0, 8, ra, rb, model_egl(ra, rb), model_lat(8, ra, rb));
    end

    for (int p = 0; p < 16; p++) begin
      logic [7:0] sa, sb;
      sa = 8'(p >> 2);
      sb = 8'(p & 3);
      run(1'b1, 2, sa, sb, model_egl(sa, sb), 2);
    end

    // start re-pulsed during SCAN is ignored.
    sel_v = 1'b0;
    drive(1'b0, 8'h12, 8'h13, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_done) begin
        ndone++;
        chk("ignore_result", {m_e, m_g, m_l}, 1);
      end
      @(negedge clk);
    end
    chk("ignore_done_count", ndone, 1);

    // start held only across the DONE edge is not accepted.
    drive(1'b0, 8'hA5, 8'hA5, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'hA5, 8'hA5, 1'b0);
    for (int i = 0; i < 20 && !m_done; i++) @(negedge clk);
    chk("done_seen", m_done, 1);
    drive(1'b0, 8'h00, 8'hFF, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'hFF, 1'b0);
    chk("start_in_done_busy", m_busy, 0);
    @(negedge clk);
    chk("start_in_done_busy2", m_busy, 0);
    chk("start_in_done_egl", {m_e, m_g, m_l}, 4);

    // rst in the 2nd SCAN cycle aborts without a done pulse.
    drive(1'b0, 8'hA5, 8'hA5, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'hA5, 8'hA5, 1'b0);
    @(negedge clk);
    chk("scan2_busy", m_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_egl", {m_e, m_g, m_l}, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_done || m_busy) ndone++;
      @(negedge clk);
    end
    chk("rst_no_later_done", ndone, 0);

    // rst and start together: rst wins.
    rst = 1'b1;
    drive(1'b0, 8'h80, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h80, 8'h00, 1'b0);
    chk("rst_start_busy", m_busy, 0);
    @(negedge clk);
    chk("rst_start_busy2", m_busy, 0);
    chk("rst_start_egl", {m_e, m_g, m_l}, 0);

    run(1'b0, 8, 8'h80, 8'h7F, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
